// File: rtl/booth_dispatch.sv
// Operand FIFO, single-job issue and result register wrapped around an external
// Booth multiplier that uses a start/done handshake.
module booth_dispatch #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_m,
  input  logic [7:0]               in_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_ans,
  output logic [7:0]               mult_m,
  output logic [7:0]               mult_r,
  output logic                     mult_start,
  input  logic [15:0]              mult_ans,
  input  logic                     mult_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] r;
  } pair_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  pair_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [TW-1:0] tmo_cnt;
  logic          push;
  logic          start_job;
  logic          capture;
  logic          time_out;
  logic          tmo_inc;
  logic          tmo_last;

  // Status flags depend on registered state only.
  assign in_ready = (count != CW'(DEPTH));
  assign busy     = (state != S_IDLE);
  assign push     = in_valid && in_ready;
  assign tmo_last = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if ((count != '0) && !out_valid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (mult_done || tmo_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Per-cycle datapath strobes decoded from the current state.
  always_comb begin
    start_job = 1'b0;
    capture   = 1'b0;
    time_out  = 1'b0;
    tmo_inc   = 1'b0;
    case (state)
      S_IDLE: start_job = (count != '0) && !out_valid;
      S_WAIT: begin
        if (mult_done)     capture  = 1'b1;
        else if (tmo_last) time_out = 1'b1;
        else               tmo_inc  = 1'b1;
      end
      default: ;
    endcase
  end

  // Storage has no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{m: in_m, r: in_r};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + PW'(1);
      if (start_job) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(start_job);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mult_m     <= '0;
      mult_r     <= '0;
      mult_start <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      mult_start <= start_job;
      if (start_job) begin
        mult_m <= mem[rd_ptr].m;
        mult_r <= mem[rd_ptr].r;
      end
      if (state == S_ISSUE) tmo_cnt <= '0;
      else if (tmo_inc)     tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Single-entry result register; a timed-out job leaves it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_ans   <= '0;
      err       <= 1'b0;
    end else begin
      if (capture) begin
        out_valid <= 1'b1;
        out_ans   <= mult_ans;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (time_out) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_booth_dispatch.sv
// Bench for booth_dispatch: behavioural multiplier, result scoreboard, vector
// table and directed sequences for backpressure, timeout and reset.
module tb_booth_dispatch;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_m;
  logic [7:0]  in_r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ans;
  logic [7:0]  mult_m;
  logic [7:0]  mult_r;
  logic        mult_start;
  logic [15:0] mult_ans;
  logic        mult_done;
  logic [3:0]  count;
  logic        busy;
  logic        err;

  booth_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_m       (in_m),
    .in_r       (in_r),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ans    (out_ans),
    .mult_m     (mult_m),
    .mult_r     (mult_r),
    .mult_start (mult_start),
    .mult_ans   (mult_ans),
    .mult_done  (mult_done),
    .count      (count),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  r;
    logic [15:0] p;
  } vec_t;

  vec_t        tbl [9];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q [$];

  // Multiplier model state
  int          lat = 9;
  bit          hang_once = 0;
  bit          job_hang = 0;
  bit          pend = 0;
  bit          stale = 0;
  int          cnt = 0;
  logic [7:0]  sm;
  logic [7:0]  sr;
  bit          prev_start = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [7:0] m, input logic [7:0] r, input logic [15:0] p,
                           input bit track);
    int n = 0;
    in_m     = m;
    in_r     = r;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) begin
      chk("push_timeout", 16'(in_ready), 16'd1);
    end else begin
      cyc();
      if (track) exp_q.push_back(p);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic sel(input int which);
    return (which == 0) ? out_valid : mult_start;
  endfunction

  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (!sel(which) && n < 300) begin
      cyc();
      n++;
    end
    chk(name, 16'(sel(which)), 16'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 && !busy && !out_valid && count == 0) && n < 1000) begin
      cyc();
      n++;
    end
    chk("drain_done", 16'(n < 1000), 16'd1);
  endtask

  // Behavioural multiplier: done pulse lat cycles after the start cycle.
  always begin
    int p;
    @(posedge clk);
    #1;
    mult_done = 1'b0;
    if (!rst) stale = 1;
    if (mult_start) begin
      pend      = 1;
      cnt       = lat;
      sm        = mult_m;
      sr        = mult_r;
      job_hang  = hang_once;
      hang_once = 0;
      stale     = 0;
    end else if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        pend = 0;
        if (!job_hang) begin
          p         = int'($signed(sm)) * int'($signed(sr));
          mult_ans  = p[15:0];
          mult_done = 1'b1;
          if (!stale) begin
            chk("mult_m_stable", 16'(mult_m), 16'(sm));
            chk("mult_r_stable", 16'(mult_r), 16'(sr));
          end
        end
      end
    end
  end

  // Scoreboard and start-pulse monitor.
  always @(negedge clk) begin
    if (rst) begin
      if (mult_start) begin
        chk("start_while_valid", 16'(out_valid), 16'd0);
        chk("start_pulse_len", 16'(prev_start), 16'd0);
      end
      prev_start = mult_start;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 16'(out_valid), 16'd0);
        else                   chk("out_ans", out_ans, exp_q.pop_front());
      end
    end else begin
      prev_start = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    tbl[0] = '{8'h21, 8'hFB, 16'hFF5B};
    tbl[1] = '{8'h80, 8'h80, 16'h4000};
    tbl[2] = '{8'h7F, 8'h80, 16'hC080};
    tbl[3] = '{8'h00, 8'hFF, 16'h0000};
    tbl[4] = '{8'hFF, 8'hFF, 16'h0001};
    tbl[5] = '{8'h03, 8'h05, 16'h000F};
    tbl[6] = '{8'h7F, 8'h7F, 16'h3F01};
    tbl[7] = '{8'hFE, 8'h05, 16'hFFF6};
    tbl[8] = '{8'h10, 8'hF0, 16'hFF00};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_m      = '0;
    in_r      = '0;
    out_ready = 1'b1;
    mult_done = 1'b0;
    mult_ans  = '0;
    repeat (2) cyc();
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_count", 16'(count), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_ans", out_ans, 16'd0);
    chk("rst_mult_start", 16'(mult_start), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    rst = 1'b1;

    // Single op held by the consumer
    out_ready = 1'b0;
    push_pair(tbl[0].m, tbl[0].r, tbl[0].p, 1);
    wait_for(0, "single_valid_rise");
    repeat (3) begin
      chk("single_hold_valid", 16'(out_valid), 16'd1);
      chk("single_hold_ans", out_ans, 16'hFF5B);
      cyc();
    end
    chk("single_err", 16'(err), 16'd0);
    out_ready = 1'b1;
    drain();

    // Vector table, extremes first
    for (int i = 1; i < 9; i++) push_pair(tbl[i].m, tbl[i].r, tbl[i].p, 1);
    drain();

    // Backpressure with five pairs
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_pair(tbl[i].m, tbl[i].r, tbl[i].p, 1);
    wait_for(0, "bp_valid_rise");
    chk("bp_count_full", 16'(count), 16'd4);
    chk("bp_in_ready", 16'(in_ready), 16'd0);
    in_m     = 8'h55;
    in_r     = 8'h55;
    in_valid = 1'b1;
    repeat (3) cyc();
    chk("bp_full_no_push", 16'(count), 16'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Push on the same edge as the pop
    out_ready = 1'b0;
    push_pair(tbl[5].m, tbl[5].r, tbl[5].p, 1);
    wait_for(0, "pp_valid_rise");
    push_pair(tbl[6].m, tbl[6].r, tbl[6].p, 1);
    push_pair(tbl[7].m, tbl[7].r, tbl[7].p, 1);
    chk("pp_count_two", 16'(count), 16'd2);
    out_ready = 1'b1;
    cyc();
    chk("pp_valid_clear", 16'(out_valid), 16'd0);
    in_m     = tbl[8].m;
    in_r     = tbl[8].r;
    in_valid = 1'b1;
    cyc();
    exp_q.push_back(tbl[8].p);
    in_valid = 1'b0;
    chk("pp_count_same", 16'(count), 16'd2);
    chk("pp_issue", 16'(mult_start), 16'd1);
    drain();

    // Timeout on a hung job, queued job follows
    hang_once = 1;
    push_pair(tbl[1].m, tbl[1].r, tbl[1].p, 0);
    wait_for(1, "to_start");
    in_m     = tbl[2].m;
    in_r     = tbl[2].r;
    in_valid = 1'b1;
    cyc();
    exp_q.push_back(tbl[2].p);
    in_valid = 1'b0;
    repeat (TIMEOUT - 1) cyc();
    chk("to_err_early", 16'(err), 16'd0);
    cyc();
    chk("to_err_set", 16'(err), 16'd1);
    chk("to_idle", 16'(busy), 16'd0);
    cyc();
    chk("to_next_issue", 16'(mult_start), 16'd1);
    drain();
    chk("to_err_sticky", 16'(err), 16'd1);

    // Reset in the middle of a job, stray done afterwards
    lat = 20;
    push_pair(tbl[3].m, tbl[3].r, tbl[3].p, 0);
    wait_for(1, "rm_start");
    push_pair(tbl[4].m, tbl[4].r, tbl[4].p, 0);
    repeat (4) cyc();
    rst = 1'b0;
    cyc();
    chk("rm_busy", 16'(busy), 16'd0);
    chk("rm_count", 16'(count), 16'd0);
    chk("rm_in_ready", 16'(in_ready), 16'd1);
    chk("rm_mult_m", 16'(mult_m), 16'd0);
    chk("rm_mult_r", 16'(mult_r), 16'd0);
    chk("rm_err", 16'(err), 16'd0);
    chk("rm_out_valid", 16'(out_valid), 16'd0);
    cyc();
    rst  = 1'b1;
    seen = 0;
    repeat (25) begin
      cyc();
      if (out_valid || busy) seen = 1;
    end
    chk("rm_stray_ignored", 16'(seen), 16'd0);
    lat = 9;
    push_pair(tbl[6].m, tbl[6].r, tbl[6].p, 1);
    drain();
    chk("rm_err_final", 16'(err), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
